// File: rtl/keycode_pkg.sv
// Shared key codes, direction/class encodings and keycode classification helpers
// for the keycode decoder path.
package keycode_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_R     = 8'h15;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [2:0] {
        KC_NONE,
        KC_P1_DIR,
        KC_P2_DIR,
        KC_P1_BOMB,
        KC_P2_BOMB,
        KC_START
    } key_class_t;

    function automatic key_class_t classify(input logic [7:0] code);
        case (code)
            KEY_W, KEY_S, KEY_A, KEY_D:               classify = KC_P1_DIR;
            KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT:    classify = KC_P2_DIR;
            KEY_SPACE:                                classify = KC_P1_BOMB;
            KEY_ENTER:                                classify = KC_P2_BOMB;
            KEY_R:                                    classify = KC_START;
            default:                                  classify = KC_NONE;
        endcase
    endfunction

    // Both players share one decode table since the two key sets never overlap.
    function automatic dir_t key_dir(input logic [7:0] code);
        case (code)
            KEY_W, KEY_UP:     key_dir = DIR_UP;
            KEY_S, KEY_DOWN:   key_dir = DIR_DOWN;
            KEY_A, KEY_LEFT:   key_dir = DIR_LEFT;
            KEY_D, KEY_RIGHT:  key_dir = DIR_RIGHT;
            default:           key_dir = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/keycode_decoder_if.sv
// Bus between the keycode PIO / frame timing side and the keycode decoder.
interface keycode_decoder_if;

    logic       frame_tick;
    logic [7:0] keycode;
    logic       enable;
    logic [7:0] stable_code;
    logic [2:0] p1_dir;
    logic       p1_move;
    logic       p1_bomb;
    logic [2:0] p2_dir;
    logic       p2_move;
    logic       p2_bomb;
    logic       start_pulse;

    modport master (
        output frame_tick, keycode, enable,
        input  stable_code, p1_dir, p1_move, p1_bomb,
        input  p2_dir, p2_move, p2_bomb, start_pulse
    );

    modport slave (
        input  frame_tick, keycode, enable,
        output stable_code, p1_dir, p1_move, p1_bomb,
        output p2_dir, p2_move, p2_bomb, start_pulse
    );

endinterface

// File: rtl/player_cmd_gen.sv
// Per-player command generator: held-direction auto-repeat and bomb cooldown,
// all paced by the frame tick.
module player_cmd_gen
    import keycode_pkg::*;
#(
    parameter int REPEAT_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 120
) (
    input  logic Clk,
    input  logic Reset,
    input  logic tick,
    input  logic is_dir,
    input  dir_t dir,
    input  logic is_bomb,
    input  logic press_edge,
    input  logic enable,
    output dir_t player_dir,
    output logic move,
    output logic bomb
);

    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [RW-1:0] REPEAT_LAST   = RW'(REPEAT_FRAMES - 1);
    localparam logic [CW-1:0] COOLDOWN_INIT = CW'(COOLDOWN_FRAMES);

    logic [RW-1:0] rep_cnt;
    logic [CW-1:0] cooldown;
    logic          pressed;

    // Pulses default low every clock so they last exactly one cycle after a tick.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            player_dir <= DIR_NONE;
            move       <= 1'b0;
            bomb       <= 1'b0;
            rep_cnt    <= '0;
            cooldown   <= '0;
            pressed    <= 1'b0;
        end else begin
            move <= 1'b0;
            bomb <= 1'b0;
            if (tick) begin
                if (is_dir && enable) begin
                    player_dir <= dir;
                    if (press_edge || !pressed) begin
                        move    <= 1'b1;
                        rep_cnt <= '0;
                        pressed <= 1'b1;
                    end else if (rep_cnt == REPEAT_LAST) begin
                        move    <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
                end else begin
                    player_dir <= DIR_NONE;
                    rep_cnt    <= '0;
                    pressed    <= 1'b0;
                end

                // Dropped presses are not remembered; only a fresh press edge can fire.
                if (is_bomb && press_edge && enable && (cooldown == '0)) begin
                    bomb     <= 1'b1;
                    cooldown <= COOLDOWN_INIT;
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/keycode_decoder.sv
// Debounces the raw HID keycode and turns it into registered, frame-paced
// commands for both players plus a start pulse.
module keycode_decoder
    import keycode_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 120
) (
    input  logic                Clk,
    input  logic                Reset,
    keycode_decoder_if.slave    bus
);

    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_FRAMES);

    logic [7:0]    cand;
    logic [DW-1:0] cnt;
    logic [7:0]    stable_q;
    logic          start_q;

    logic [DW-1:0] cnt_next;
    logic [7:0]    stable_next;
    logic          press_edge;
    key_class_t    cls;
    dir_t          dir_next;

    dir_t p1_dir_w;
    dir_t p2_dir_w;
    logic p1_move_w, p1_bomb_w, p2_move_w, p2_bomb_w;

    // Class and direction come from the post-tick stable code so commands
    // follow the same tick that accepts a new key.
    always_comb begin
        cnt_next    = cnt;
        press_edge  = 1'b0;
        stable_next = stable_q;
        if (bus.keycode != cand) begin
            cnt_next = DW'(1);
        end else if (cnt != DEB_MAX) begin
            cnt_next = cnt + DW'(1);
        end
        if (bus.frame_tick && (cnt_next == DEB_MAX) && (bus.keycode != stable_q)) begin
            press_edge  = 1'b1;
            stable_next = bus.keycode;
        end
        cls      = classify(stable_next);
        dir_next = key_dir(stable_next);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cand     <= '0;
            cnt      <= '0;
            stable_q <= '0;
            start_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (bus.frame_tick) begin
                cand     <= bus.keycode;
                cnt      <= cnt_next;
                stable_q <= stable_next;
                if (press_edge && (cls == KC_START)) begin
                    start_q <= 1'b1;
                end
            end
        end
    end

    player_cmd_gen #(
        .REPEAT_FRAMES   (REPEAT_FRAMES),
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
    ) u_p1 (
        .Clk        (Clk),
        .Reset      (Reset),
        .tick       (bus.frame_tick),
        .is_dir     (cls == KC_P1_DIR),
        .dir        (dir_next),
        .is_bomb    (cls == KC_P1_BOMB),
        .press_edge (press_edge),
        .enable     (bus.enable),
        .player_dir (p1_dir_w),
        .move       (p1_move_w),
        .bomb       (p1_bomb_w)
    );

    player_cmd_gen #(
        .REPEAT_FRAMES   (REPEAT_FRAMES),
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
    ) u_p2 (
        .Clk        (Clk),
        .Reset      (Reset),
        .tick       (bus.frame_tick),
        .is_dir     (cls == KC_P2_DIR),
        .dir        (dir_next),
        .is_bomb    (cls == KC_P2_BOMB),
        .press_edge (press_edge),
        .enable     (bus.enable),
        .player_dir (p2_dir_w),
        .move       (p2_move_w),
        .bomb       (p2_bomb_w)
    );

    assign bus.stable_code = stable_q;
    assign bus.start_pulse = start_q;
    assign bus.p1_dir      = p1_dir_w;
    assign bus.p1_move     = p1_move_w;
    assign bus.p1_bomb     = p1_bomb_w;
    assign bus.p2_dir      = p2_dir_w;
    assign bus.p2_move     = p2_move_w;
    assign bus.p2_bomb     = p2_bomb_w;

endmodule

// File: tb/tb_keycode_decoder.sv
// Directed self-checking bench for keycode_decoder with default parameters;
// frame ticks are issued every 4 clocks and pulses are tallied on the falling edge.
module tb_keycode_decoder;

    logic Clk = 1'b0;
    logic Reset;

    keycode_decoder_if kif ();

    keycode_decoder dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (kif.slave)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int tick_idx = 0;
    int p1_move_cnt = 0, p1_bomb_cnt = 0, p2_move_cnt = 0, p2_bomb_cnt = 0, start_cnt = 0;
    int last_p1_move = -1, last_p1_bomb = -1, last_p2_move = -1;
    int base, b2;

    // Each high sample is one pulse; a pulse stuck high would be tallied twice.
    always @(negedge Clk) begin
        if (kif.p1_move === 1'b1) begin p1_move_cnt++; last_p1_move = tick_idx; end
        if (kif.p1_bomb === 1'b1) begin p1_bomb_cnt++; last_p1_bomb = tick_idx; end
        if (kif.p2_move === 1'b1) begin p2_move_cnt++; last_p2_move = tick_idx; end
        if (kif.p2_bomb === 1'b1) p2_bomb_cnt++;
        if (kif.start_pulse === 1'b1) start_cnt++;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic do_tick();
        @(negedge Clk);
        tick_idx++;
        kif.frame_tick = 1'b1;
        @(negedge Clk);
        kif.frame_tick = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] code, input int n);
        kif.keycode = code;
        for (int i = 0; i < n; i++) do_tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset          = 1'b0;
        kif.keycode    = 8'h1A;
        kif.frame_tick = 1'b1;
        kif.enable     = 1'b1;
        repeat (3) @(negedge Clk);
        check_output("rst_stable", kif.stable_code, 0);
        check_output("rst_dirs", {kif.p1_dir, kif.p2_dir}, 0);
        check_output("rst_pulses", {kif.p1_move, kif.p1_bomb, kif.p2_move, kif.p2_bomb, kif.start_pulse}, 0);
        check_output("rst_pulse_cnt", p1_move_cnt + p1_bomb_cnt + p2_move_cnt + p2_bomb_cnt + start_cnt, 0);
        kif.frame_tick = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;

        $display("[TB] hold W with auto-repeat");
        base = tick_idx;
        apply_stimulus(8'h1A, 1);
        check_output("w_tick1_no_move", p1_move_cnt, 0);
        apply_stimulus(8'h1A, 1);
        check_output("w_tick2_move", p1_move_cnt, 1);
        check_output("w_tick2_dir", kif.p1_dir, 1);
        check_output("w_stable", kif.stable_code, 8'h1A);
        apply_stimulus(8'h1A, 7);
        check_output("w_tick9_no_repeat", p1_move_cnt, 1);
        apply_stimulus(8'h1A, 1);
        check_output("w_tick10_repeat", last_p1_move - base, 10);
        apply_stimulus(8'h1A, 16);
        check_output("w_tick26_count", p1_move_cnt, 4);
        check_output("w_tick26_last", last_p1_move - base, 26);
        apply_stimulus(8'h00, 1);
        check_output("w_release1_dir", kif.p1_dir, 1);
        apply_stimulus(8'h00, 1);
        check_output("w_release2_dir", kif.p1_dir, 0);
        check_output("w_release_stable", kif.stable_code, 0);
        check_output("w_release_count", p1_move_cnt, 4);

        $display("[TB] single-tick glitch on D");
        apply_stimulus(8'h07, 1);
        apply_stimulus(8'h00, 2);
        check_output("glitch_stable", kif.stable_code, 0);
        check_output("glitch_move", p1_move_cnt, 4);
        check_output("glitch_dir", kif.p1_dir, 0);

        $display("[TB] bomb hold and cooldown");
        base = tick_idx;
        apply_stimulus(8'h2C, 300);
        check_output("bomb_hold_count", p1_bomb_cnt, 1);
        check_output("bomb_hold_tick", last_p1_bomb - base, 2);
        apply_stimulus(8'h00, 2);
        apply_stimulus(8'h2C, 2);
        check_output("bomb_repress_fires", p1_bomb_cnt, 2);
        b2 = last_p1_bomb;
        check_output("bomb_repress_tick", b2, tick_idx);
        apply_stimulus(8'h00, (b2 + 58) - tick_idx);
        apply_stimulus(8'h2C, 2);
        check_output("bomb_at_60_dropped", p1_bomb_cnt, 2);
        apply_stimulus(8'h00, (b2 + 128) - tick_idx);
        apply_stimulus(8'h2C, 2);
        check_output("bomb_at_130_fires", p1_bomb_cnt, 3);
        check_output("bomb_at_130_tick", last_p1_bomb - b2, 130);
        apply_stimulus(8'h00, 2);

        $display("[TB] P2 up with enable low then high");
        kif.enable = 1'b0;
        apply_stimulus(8'h52, 20);
        check_output("p2_disabled_dir", kif.p2_dir, 0);
        check_output("p2_disabled_move", p2_move_cnt, 0);
        kif.enable = 1'b1;
        apply_stimulus(8'h52, 1);
        check_output("p2_enable_move", p2_move_cnt, 1);
        check_output("p2_enable_dir", kif.p2_dir, 1);
        base = tick_idx;
        apply_stimulus(8'h52, 7);
        check_output("p2_no_early_repeat", p2_move_cnt, 1);
        apply_stimulus(8'h52, 1);
        check_output("p2_repeat", p2_move_cnt, 2);
        check_output("p2_repeat_tick", last_p2_move - base, 8);

        $display("[TB] start key with enable low");
        kif.enable = 1'b0;
        apply_stimulus(8'h15, 2);
        check_output("start_count", start_cnt, 1);
        check_output("start_p2_dir", kif.p2_dir, 0);
        apply_stimulus(8'h00, 2);
        check_output("start_no_repeat", start_cnt, 1);
        check_output("no_p2_bomb", p2_bomb_cnt, 0);

        $display("[TB] reset in the middle of a P2 repeat");
        kif.enable = 1'b1;
        apply_stimulus(8'h4F, 2);
        check_output("right_move", p2_move_cnt, 3);
        check_output("right_dir", kif.p2_dir, 4);
        apply_stimulus(8'h4F, 3);
        @(negedge Clk);
        Reset          = 1'b0;
        kif.frame_tick = 1'b1;
        repeat (12) @(negedge Clk);
        #1;
        check_output("mid_reset_dir", kif.p2_dir, 0);
        check_output("mid_reset_stable", kif.stable_code, 0);
        check_output("mid_reset_no_pulse", p2_move_cnt, 3);
        kif.frame_tick = 1'b0;
        Reset          = 1'b1;
        base = tick_idx;
        apply_stimulus(8'h4F, 1);
        check_output("post_reset_tick1", p2_move_cnt, 3);
        apply_stimulus(8'h4F, 1);
        check_output("post_reset_tick2", p2_move_cnt, 4);
        check_output("post_reset_tick2_at", last_p2_move - base, 2);
        check_output("post_reset_dir", kif.p2_dir, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keycode_decoder.md
Name: keycode_decoder

Overview:
- Receiving end of the keycode path. Takes the 8-bit USB HID keycode written by the NIOS keycode PIO and turns it into registered, frame-paced game commands for both players: direction, move pulses and bomb pulses, plus a start pulse.
- Replaces ad-hoc keycode compares in the player modules.
- Sits between the keycode PIO and the user1/user2/bomb/state_machine blocks.
- Paced by a one-cycle frame_tick (one per VGA frame) rather than clocking on VGA_VS.

Parameters:
- DEBOUNCE_FRAMES, 2, consecutive identical tick samples required before a keycode is accepted (1..15).
- REPEAT_FRAMES, 8, ticks between repeated move pulses while a direction key is held (1..255).
- COOLDOWN_FRAMES, 120, ticks after a bomb pulse during which that player's bomb key is ignored (1..1023).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset; single clock domain.
- frame_tick  in  1  one-Clk pulse per frame.
- keycode  in  8  raw HID keycode; 0x00 = no key.
- enable  in  1  gameplay allowed; low suppresses move/bomb commands.
- stable_code  out  8  debounced keycode.
- p1_dir  out  3  P1 direction: 0 none, 1 up, 2 down, 3 left, 4 right.
- p1_move  out  1  one-Clk move pulse.
- p1_bomb  out  1  one-Clk bomb pulse.
- p2_dir  out  3  P2 direction, same encoding as p1_dir.
- p2_move  out  1  one-Clk move pulse.
- p2_bomb  out  1  one-Clk bomb pulse.
- start_pulse  out  1  one-Clk start/restart pulse.

Behaviour:
- Reset low at a Clk edge clears everything, and it dominates frame_tick in the same cycle. Cleared state: cand=0, cnt=0, stable_code=0, all dir outputs 0, all pulse outputs 0, repeat and cooldown counters 0, pressed flags 0. Reset mid-repeat or mid-cooldown aborts with no residual pulse.
- All state updates only on Clk edges where frame_tick=1. Exception: pulse outputs self-clear on the next Clk.
- All outputs are registered. Pulses are high exactly for the cycle after the qualifying tick.
- Debounce, evaluated on each tick:
  - keycode!=cand: cand<=keycode, cnt<=1.
  - Otherwise cnt saturating-increments to DEBOUNCE_FRAMES.
  - When the new cnt equals DEBOUNCE_FRAMES and keycode!=stable_code, stable_code<=keycode. That is a "press edge".
- Key map (next-state stable_code):
  - P1: W 0x1A up, S 0x16 down, A 0x04 left, D 0x07 right, Space 0x2C bomb.
  - P2: arrows Up 0x52, Down 0x51, Left 0x50, Right 0x4F; Enter 0x28 bomb.
  - R 0x15 start. Any other code, including 0x00, is class NONE.
- Only one key exists at a time, so at most one class is active.
- Move, per player:
  - If the stable class is that player's direction and enable=1: dir=mapped value.
  - On a press edge, or on the first tick with enable=1 while the key is held (pressed flag clear): move pulse, repeat counter<=0, pressed<=1.
  - Otherwise repeat counter+1; on reaching REPEAT_FRAMES, move pulse and counter<=0.
  - Other class or enable=0: dir=0, counter<=0, pressed<=0.
- Bomb, per player:
  - Cooldown decrements to 0 every tick regardless of enable.
  - Press edge on the bomb key with enable=1 and cooldown==0: bomb pulse, cooldown<=COOLDOWN_FRAMES.
  - Presses during cooldown or with enable=0 are dropped, not queued.
  - Holding the key never re-fires.
- Start: pulse on press edge of 0x15, independent of enable.
- Widths: counters are $clog2(param+1) bits, unsigned, saturating, with no wrap.
- frame_tick asserted on consecutive cycles is legal; each cycle counts as a tick.

Decomposition:
- Package keycode_pkg:
  - localparams for every key code.
  - typedef enum logic [2:0] dir_t {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}.
  - typedef enum key_class_t {KC_NONE, KC_P1_DIR, KC_P2_DIR, KC_P1_BOMB, KC_P2_BOMB, KC_START}.
- Sub-module player_cmd_gen, instantiated twice (P1, P2):
  - Contains the repeat counter, pressed flag and cooldown counter.
  - Parameterised by REPEAT_FRAMES/COOLDOWN_FRAMES.
  - Inputs: tick, is_dir, dir, is_bomb, press_edge, enable.

Test Plan:
- Reset: Reset=0 for 3 cycles with keycode=0x1A and frame_tick=1 -> every output 0, no pulses, stable_code=0x00.
- Hold 0x1A, tick every 4 cycles, defaults, enable=1 -> no pulse after tick1. p1_move pulse with p1_dir=1 after tick2. Further pulses after ticks 10, 18, 26. Release to 0x00 -> p1_dir=0 after the second 0x00 tick.
- Glitch: 0x07 for one tick, then 0x00 -> stable_code stays 0x00, no p1_move, p1_dir=0.
- Hold 0x2C for 300 ticks -> exactly one p1_bomb, at tick 2. Release, then re-press so that it becomes stable 60 ticks after the bomb -> dropped. Re-press stable at 130 ticks after -> second p1_bomb.
- Hold 0x52 with enable=0 for 20 ticks -> p2_dir=0, no pulses. Raise enable -> p2_move pulse and p2_dir=1 after the next tick, then a repeat 8 ticks later. Pulse 0x15 for 2 ticks with enable=0 -> one start_pulse.
- Hold 0x4F, pull Reset low between repeat pulses, release Reset -> no pulse during reset. Key still held -> new p2_move 2 ticks after release.
